// File: rtl/fpu_addsub_operand_stage_pkg.sv
// Shared binary32 field definitions, rounding-mode encodings, FCLASS bit indices and the
// classified-operand / stage payload bundles for the FP add/sub operand stage.
package fpu_addsub_operand_stage_pkg;

  localparam int unsigned WordW  = 32;
  localparam int unsigned ExpW   = 8;
  localparam int unsigned SigW   = 23;
  localparam int unsigned ClassW = 10;
  localparam int unsigned RmW    = 3;

  localparam logic [ExpW-1:0] ExpMax = 8'hFF;

  localparam logic [RmW-1:0] RmRne = 3'b000;
  localparam logic [RmW-1:0] RmRtz = 3'b001;
  localparam logic [RmW-1:0] RmRdn = 3'b010;
  localparam logic [RmW-1:0] RmRup = 3'b011;
  localparam logic [RmW-1:0] RmRmm = 3'b100;
  localparam logic [RmW-1:0] RmDyn = 3'b111;

  localparam int unsigned ClsNegInf  = 0;
  localparam int unsigned ClsNegNorm = 1;
  localparam int unsigned ClsNegSubn = 2;
  localparam int unsigned ClsNegZero = 3;
  localparam int unsigned ClsPosZero = 4;
  localparam int unsigned ClsPosSubn = 5;
  localparam int unsigned ClsPosNorm = 6;
  localparam int unsigned ClsPosInf  = 7;
  localparam int unsigned ClsSnan    = 8;
  localparam int unsigned ClsQnan    = 9;

  typedef struct packed {
    logic              sign;
    logic [ExpW-1:0]   exp;
    logic [SigW-1:0]   sig;
    logic              is_zero;
    logic              is_subn;
    logic              is_inf;
    logic              is_nan;
    logic              is_snan;
    logic [ClassW-1:0] fclass;
  } operand_t;

  typedef struct packed {
    logic [RmW-1:0] rm;
    logic           sub;
    logic           illegal_rm;
    logic           is_signaling;
    operand_t       a;
    operand_t       b;
  } payload_t;

endpackage

// File: rtl/fpu_operand_classify.sv
// Combinational unpack and classification of one binary32 operand, including its FCLASS mask.
module fpu_operand_classify
  import fpu_addsub_operand_stage_pkg::*;
(
  input  logic [WordW-1:0] op_i,
  output operand_t         opnd_o
);

  logic            sign;
  logic [ExpW-1:0] exp;
  logic [SigW-1:0] sig;
  logic            exp_zero, exp_max, sig_zero;
  logic            is_zero, is_subn, is_inf, is_nan, is_norm;

  assign sign     = op_i[WordW-1];
  assign exp      = op_i[WordW-2 -: ExpW];
  assign sig      = op_i[SigW-1:0];
  assign exp_zero = (exp == '0);
  assign exp_max  = (exp == ExpMax);
  assign sig_zero = (sig == '0);

  assign is_zero = exp_zero & sig_zero;
  assign is_subn = exp_zero & ~sig_zero;
  assign is_inf  = exp_max & sig_zero;
  assign is_nan  = exp_max & ~sig_zero;
  assign is_norm = ~exp_zero & ~exp_max;

  always_comb begin
    opnd_o         = '0;
    opnd_o.sign    = sign;
    opnd_o.exp     = exp;
    opnd_o.sig     = sig;
    opnd_o.is_zero = is_zero;
    opnd_o.is_subn = is_subn;
    opnd_o.is_inf  = is_inf;
    opnd_o.is_nan  = is_nan;
    // Quiet bit is the MSB of the significand; sign plays no part for NaNs.
    opnd_o.is_snan = is_nan & ~sig[SigW-1];

    opnd_o.fclass[ClsNegInf]  = is_inf & sign;
    opnd_o.fclass[ClsNegNorm] = is_norm & sign;
    opnd_o.fclass[ClsNegSubn] = is_subn & sign;
    opnd_o.fclass[ClsNegZero] = is_zero & sign;
    opnd_o.fclass[ClsPosZero] = is_zero & ~sign;
    opnd_o.fclass[ClsPosSubn] = is_subn & ~sign;
    opnd_o.fclass[ClsPosNorm] = is_norm & ~sign;
    opnd_o.fclass[ClsPosInf]  = is_inf & ~sign;
    opnd_o.fclass[ClsSnan]    = is_nan & ~sig[SigW-1];
    opnd_o.fclass[ClsQnan]    = is_nan & sig[SigW-1];
  end

endmodule

// File: rtl/fpu_addsub_operand_stage.sv
// FP add/sub front end: classifies both operands, resolves the rounding mode and registers the
// result behind a valid/ready handshake with an output register plus one skid entry.
module fpu_addsub_operand_stage
  import fpu_addsub_operand_stage_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WordW-1:0]  op_a_i,
  input  logic [WordW-1:0]  op_b_i,
  input  logic              sub_i,
  input  logic [RmW-1:0]    rm_i,
  input  logic [RmW-1:0]    frm_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RmW-1:0]    rounding_mode_o,
  output logic              sub_op_o,
  output logic              sign_a_o,
  output logic              sign_b_o,
  output logic [ExpW-1:0]   exp_a_o,
  output logic [ExpW-1:0]   exp_b_o,
  output logic [SigW-1:0]   sig_a_o,
  output logic [SigW-1:0]   sig_b_o,
  output logic              is_zero_a_o,
  output logic              is_zero_b_o,
  output logic              is_inf_a_o,
  output logic              is_inf_b_o,
  output logic              is_nan_a_o,
  output logic              is_nan_b_o,
  output logic              is_subn_a_o,
  output logic              is_subn_b_o,
  output logic              is_signaling_o,
  output logic              illegal_rm_o,
  output logic [ClassW-1:0] class_a_o,
  output logic [ClassW-1:0] class_b_o,
  output logic [TAG_W-1:0]  tag_o
);

  operand_t       opnd_a, opnd_b;
  payload_t       in_pay;
  logic [RmW-1:0] rm_res;
  logic           accept, out_load;

  payload_t   out_pay_q, out_pay_d, skid_pay_q, skid_pay_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic       out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  fpu_operand_classify u_classify_a (
    .op_i   (op_a_i),
    .opnd_o (opnd_a)
  );

  fpu_operand_classify u_classify_b (
    .op_i   (op_b_i),
    .opnd_o (opnd_b)
  );

  assign rm_res = (rm_i == RmDyn) ? frm_i : rm_i;

  always_comb begin
    in_pay              = '0;
    in_pay.rm           = rm_res;
    in_pay.sub          = sub_i;
    in_pay.illegal_rm   = rm_res[2] & (rm_res[1] | rm_res[0]);
    in_pay.is_signaling = opnd_a.is_snan | opnd_b.is_snan;
    in_pay.a            = opnd_a;
    in_pay.b            = opnd_b;
  end

  // Ready depends only on registered skid state, never on out_ready_i.
  assign in_ready_o = ~skid_valid_q;
  assign accept     = in_valid_i & in_ready_o;
  assign out_load   = ~out_valid_q | out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pay_d    = out_pay_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;
    skid_tag_d   = skid_tag_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pay_d    = skid_pay_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pay_d   = in_pay;
        out_tag_d   = tag_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = in_pay;
      skid_tag_d   = tag_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      out_pay_q    <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pay_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pay_q    <= out_pay_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign rounding_mode_o = out_pay_q.rm;
  assign sub_op_o        = out_pay_q.sub;
  assign illegal_rm_o    = out_pay_q.illegal_rm;
  assign is_signaling_o  = out_pay_q.is_signaling;
  assign sign_a_o        = out_pay_q.a.sign;
  assign sign_b_o        = out_pay_q.b.sign;
  assign exp_a_o         = out_pay_q.a.exp;
  assign exp_b_o         = out_pay_q.b.exp;
  assign sig_a_o         = out_pay_q.a.sig;
  assign sig_b_o         = out_pay_q.b.sig;
  assign is_zero_a_o     = out_pay_q.a.is_zero;
  assign is_zero_b_o     = out_pay_q.b.is_zero;
  assign is_inf_a_o      = out_pay_q.a.is_inf;
  assign is_inf_b_o      = out_pay_q.b.is_inf;
  assign is_nan_a_o      = out_pay_q.a.is_nan;
  assign is_nan_b_o      = out_pay_q.b.is_nan;
  assign is_subn_a_o     = out_pay_q.a.is_subn;
  assign is_subn_b_o     = out_pay_q.b.is_subn;
  assign class_a_o       = out_pay_q.a.fclass;
  assign class_b_o       = out_pay_q.b.fclass;
  assign tag_o           = out_tag_q;

endmodule

// File: tb/tb_fpu_addsub_operand_stage.sv
// Bench for the FP add/sub operand stage: directed spec cases, then random traffic checked
// against a queue-based reference of expected outputs.
module tb_fpu_addsub_operand_stage;

  localparam int unsigned TagW = 5;

  logic            clk;
  logic            reset_i;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     op_a_i, op_b_i;
  logic            sub_i;
  logic [2:0]      rm_i, frm_i;
  logic [TagW-1:0] tag_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [2:0]      rounding_mode_o;
  logic            sub_op_o;
  logic            sign_a_o, sign_b_o;
  logic [7:0]      exp_a_o, exp_b_o;
  logic [22:0]     sig_a_o, sig_b_o;
  logic            is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o;
  logic            is_nan_a_o, is_nan_b_o, is_subn_a_o, is_subn_b_o;
  logic            is_signaling_o, illegal_rm_o;
  logic [9:0]      class_a_o, class_b_o;
  logic [TagW-1:0] tag_o;

  fpu_addsub_operand_stage #(.TAG_W(TagW)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .op_a_i          (op_a_i),
    .op_b_i          (op_b_i),
    .sub_i           (sub_i),
    .rm_i            (rm_i),
    .frm_i           (frm_i),
    .tag_i           (tag_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .rounding_mode_o (rounding_mode_o),
    .sub_op_o        (sub_op_o),
    .sign_a_o        (sign_a_o),
    .sign_b_o        (sign_b_o),
    .exp_a_o         (exp_a_o),
    .exp_b_o         (exp_b_o),
    .sig_a_o         (sig_a_o),
    .sig_b_o         (sig_b_o),
    .is_zero_a_o     (is_zero_a_o),
    .is_zero_b_o     (is_zero_b_o),
    .is_inf_a_o      (is_inf_a_o),
    .is_inf_b_o      (is_inf_b_o),
    .is_nan_a_o      (is_nan_a_o),
    .is_nan_b_o      (is_nan_b_o),
    .is_subn_a_o     (is_subn_a_o),
    .is_subn_b_o     (is_subn_b_o),
    .is_signaling_o  (is_signaling_o),
    .illegal_rm_o    (illegal_rm_o),
    .class_a_o       (class_a_o),
    .class_b_o       (class_b_o),
    .tag_o           (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_total = 0;
  int unsigned  n_bad   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] dut_vec;

  assign dut_vec = 128'({rounding_mode_o, sub_op_o,
                         sign_a_o, exp_a_o, sig_a_o, is_zero_a_o, is_inf_a_o, is_nan_a_o, is_subn_a_o,
                         sign_b_o, exp_b_o, sig_b_o, is_zero_b_o, is_inf_b_o, is_nan_b_o, is_subn_b_o,
                         is_signaling_o, illegal_rm_o, class_a_o, class_b_o, tag_o});

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FCLASS index picked straight from the IEEE category table.
  function automatic logic [9:0] ref_class(input logic [31:0] x);
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    int         idx;
    s = x[31];
    e = x[30:23];
    m = x[22:0];
    if (e == 8'd255 && m != 0)      idx = m[22] ? 9 : 8;
    else if (e == 8'd255)           idx = s ? 0 : 7;
    else if (e == 8'd0 && m == 0)   idx = s ? 3 : 4;
    else if (e == 8'd0)             idx = s ? 2 : 5;
    else                            idx = s ? 1 : 6;
    return 10'(1) << idx;
  endfunction

  function automatic logic [35:0] ref_fields(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    return {x[31], e, m, (e == 0 && m == 0), (e == 255 && m == 0), (e == 255 && m != 0),
            (e == 0 && m != 0)};
  endfunction

  function automatic logic ref_snan(input logic [31:0] x);
    return (x[30:23] == 8'd255) && (x[22:0] != 0) && !x[22];
  endfunction

  function automatic logic [127:0] ref_out(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic [2:0] rm,
                                           input logic [2:0] frm, input logic [TagW-1:0] t);
    logic [2:0] r;
    logic       ill;
    r   = (rm == 3'd7) ? frm : rm;
    ill = (r == 3'd5) || (r == 3'd6) || (r == 3'd7);
    return 128'({r, s, ref_fields(a), ref_fields(b), ref_snan(a) | ref_snan(b), ill,
                 ref_class(a), ref_class(b), t});
  endfunction

  function automatic logic [31:0] gen_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       begin e = 8'd0;   m = 23'd0; end
      1:       begin e = 8'd0;   m = 23'($urandom) | 23'd1; end
      2:       begin e = 8'd255; m = 23'd0; end
      3:       begin e = 8'd255; m = 23'($urandom) | 23'd1; end
      default: begin e = 8'($urandom_range(1, 254)); m = 23'($urandom); end
    endcase
    return {s, e, m};
  endfunction

  // One clock: check state vs model, drive inputs, advance model, then wait to the next negedge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [2:0] rm, input logic [2:0] frm, input logic [TagW-1:0] t,
                      input logic ordy, input logic fl);
    logic rdy_m;
    check_eq("out_valid", 128'(out_valid_o), 128'(exp_q.size() > 0));
    check_eq("in_ready", 128'(in_ready_o), 128'(exp_q.size() < 2));
    if (exp_q.size() > 0) check_eq("payload", dut_vec, exp_q[0]);
    in_valid_i  = v;
    op_a_i      = a;
    op_b_i      = b;
    sub_i       = s;
    rm_i        = rm;
    frm_i       = frm;
    tag_i       = t;
    out_ready_i = ordy;
    flush_i     = fl;
    rdy_m = (exp_q.size() < 2);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
      if (v && rdy_m) exp_q.push_back(ref_out(a, b, s, rm, frm, t));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0; in_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; sub_i = 1'b0;
    rm_i = '0; frm_i = '0; tag_i = '0; out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 128'(out_valid_o), 128'(0));
    check_eq("rst_ready", 128'(in_ready_o), 128'(1));
    check_eq("rst_data", dut_vec, 128'(0));
    reset_i = 1'b0;
    @(negedge clk);

    // 1.0 + 2.0
    step(1, 32'h3F800000, 32'h40000000, 0, 3'b000, 3'b000, 5'd1, 1, 0);
    check_eq("ex1_valid", 128'(out_valid_o), 128'(1));
    check_eq("ex1_class_a", 128'(class_a_o), 128'h040);
    check_eq("ex1_class_b", 128'(class_b_o), 128'h040);
    check_eq("ex1_sub", 128'(sub_op_o), 128'(0));

    step(1, 32'h7F800001, 32'hFF800000, 1, 3'b001, 3'b000, 5'd2, 1, 0);
    check_eq("ex2_nan_a", 128'(is_nan_a_o), 128'(1));
    check_eq("ex2_sig", 128'(is_signaling_o), 128'(1));
    check_eq("ex2_class_a", 128'(class_a_o), 128'h100);
    check_eq("ex2_inf_b", 128'(is_inf_b_o), 128'(1));
    check_eq("ex2_class_b", 128'(class_b_o), 128'h001);

    step(1, 32'h80000000, 32'h00000001, 0, 3'b111, 3'b010, 5'd3, 1, 0);
    check_eq("ex3_rm", 128'(rounding_mode_o), 128'(3'b010));
    check_eq("ex3_class_a", 128'(class_a_o), 128'h008);
    check_eq("ex3_class_b", 128'(class_b_o), 128'h020);
    check_eq("ex3_illegal", 128'(illegal_rm_o), 128'(0));
    step(1, 32'h80000000, 32'h00000001, 0, 3'b111, 3'b101, 5'd4, 1, 0);
    check_eq("ex3b_rm", 128'(rounding_mode_o), 128'(3'b101));
    check_eq("ex3b_illegal", 128'(illegal_rm_o), 128'(1));
    step(0, '0, '0, 0, 3'b000, 3'b000, 5'd0, 1, 0);

    // Back-to-back with a stalled consumer.
    step(1, 32'h3F800000, 32'h3F800000, 0, 3'b000, 3'b000, 5'd11, 0, 0);
    step(1, 32'h40000000, 32'h40000000, 1, 3'b001, 3'b000, 5'd12, 0, 0);
    check_eq("b2b_ready_low", 128'(in_ready_o), 128'(0));
    check_eq("b2b_head", 128'(tag_o), 128'(5'd11));
    step(1, 32'h40400000, 32'h40400000, 0, 3'b010, 3'b000, 5'd13, 0, 0);
    step(1, 32'h40400000, 32'h40400000, 0, 3'b010, 3'b000, 5'd13, 1, 0);
    check_eq("b2b_second", 128'(tag_o), 128'(5'd12));
    step(1, 32'h40400000, 32'h40400000, 0, 3'b010, 3'b000, 5'd13, 1, 0);
    check_eq("b2b_third", 128'(tag_o), 128'(5'd13));
    step(0, '0, '0, 0, 3'b000, 3'b000, 5'd0, 1, 0);

    // Flush with both entries full, then flush while accepting.
    step(1, 32'h3F800000, 32'h0, 0, 3'b000, 3'b000, 5'd21, 0, 0);
    step(1, 32'h3F800000, 32'h0, 0, 3'b000, 3'b000, 5'd22, 0, 0);
    step(1, 32'h3F800000, 32'h0, 0, 3'b000, 3'b000, 5'd23, 0, 1);
    check_eq("flush_valid", 128'(out_valid_o), 128'(0));
    check_eq("flush_ready", 128'(in_ready_o), 128'(1));
    step(1, 32'h3F800000, 32'h0, 0, 3'b000, 3'b000, 5'd24, 0, 0);
    step(1, 32'h3F800000, 32'h0, 0, 3'b000, 3'b000, 5'd25, 0, 1);
    check_eq("flush2_valid", 128'(out_valid_o), 128'(0));
    step(0, '0, '0, 0, 3'b000, 3'b000, 5'd0, 1, 0);
    step(0, '0, '0, 0, 3'b000, 3'b000, 5'd0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), gen_op(), gen_op(), 1'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), TagW'($urandom),
           1'($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset while holding an operation.
    step(1, 32'h3F800000, 32'h40000000, 0, 3'b000, 3'b000, 5'd30, 0, 0);
    step(0, '0, '0, 0, 3'b000, 3'b000, 5'd0, 0, 0);
    in_valid_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    check_eq("areset_valid", 128'(out_valid_o), 128'(0));
    check_eq("areset_ready", 128'(in_ready_o), 128'(1));
    check_eq("areset_data", dut_vec, 128'(0));
    exp_q.delete();
    @(negedge clk);
    reset_i = 1'b0;
    step(0, '0, '0, 0, 3'b000, 3'b000, 5'd0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
